// File: rtl/serdes_rx_packer.sv
// rtl/serdes_rx_packer.sv - packs PACK_RATIO serdes words into one wide word behind a small output FIFO
module serdes_rx_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int OUT_DEPTH  = 2,
    localparam int CW = $clog2(PACK_RATIO + 1),
    localparam int WW = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  valid_in_i,
    input  logic                  flush_i,
    output logic [WW-1:0]         data_out_o,
    output logic [PACK_RATIO-1:0] keep_o,
    output logic                  valid_out_o,
    input  logic                  ready_in_i,
    output logic [CW-1:0]         lane_count_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i
);
    localparam int LW = $clog2(PACK_RATIO);
    localparam int OW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int EW = PACK_RATIO + WW;

    logic [DATA_WIDTH-1:0] lanes [PACK_RATIO];
    logic [CW-1:0]         count;
    logic [CW-1:0]         fill;
    logic [WW-1:0]         packed_word;
    logic [PACK_RATIO-1:0] packed_keep;
    logic                  push, push_ok, pop, drop;

    logic [EW-1:0] mem [OUT_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [OW-1:0] occ, occ_left, occ_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Packed word merges stored lanes with the same-cycle input; lanes past the fill level read zero.
    always_comb begin
        fill        = count + CW'(valid_in_i);
        push        = (valid_in_i && count == CW'(PACK_RATIO - 1)) || (flush_i && fill != '0);
        packed_word = '0;
        packed_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            packed_keep[i] = CW'(i) < fill;
            if (CW'(i) < count)
                packed_word[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
            else if (CW'(i) == count && valid_in_i)
                packed_word[i*DATA_WIDTH +: DATA_WIDTH] = data_in_i;
        end
    end

    always_comb begin
        pop      = valid_out_o && ready_in_i;
        push_ok  = push && (occ != OW'(OUT_DEPTH) || pop);
        drop     = push && !push_ok;
        rd_next  = pop ? ptr_inc(rd_ptr) : rd_ptr;
        occ_left = occ - OW'(pop);
        occ_next = occ_left + OW'(push_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
            for (int i = 0; i < PACK_RATIO; i++) lanes[i] <= '0;
        end else if (push) begin
            count <= '0;
        end else if (valid_in_i) begin
            lanes[count[LW-1:0]] <= data_in_i;
            count                <= count + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= {packed_keep, packed_word};
    end

    // Output registers track the next head so the outputs hold their last value once drained.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            valid_out_o <= 1'b0;
            data_out_o  <= '0;
            keep_o      <= '0;
            overflow_o  <= 1'b0;
        end else begin
            rd_ptr      <= rd_next;
            occ         <= occ_next;
            valid_out_o <= occ_next != '0;
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (occ_next != '0) begin
                if (occ_left == '0)
                    {keep_o, data_out_o} <= {packed_keep, packed_word};
                else
                    {keep_o, data_out_o} <= mem[rd_next];
            end
            if (drop)
                overflow_o <= 1'b1;
            else if (overflow_clr_i)
                overflow_o <= 1'b0;
        end
    end

    assign lane_count_o = count;
endmodule
